lif_cell_array: RTL and testbench

LIF_CELL_ARRAY -- requirements
Module: lif_cell_array

---
 rtl/lif_cell_array.sv | 112 +++++++++++
 tb/tb_lif_cell_array.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_cell_array.sv
// rtl/lif_cell_array.sv - leaky integrate-and-fire cell with popcount excitation,
// refractory hold and LFSR-broken tie on the winning neighbour port.
module lif_cell_array #(
    parameter int          NIN       = 4,
    parameter int          W         = 4,
    parameter int          ACC_W     = 8,
    parameter int          THRESH    = 16,
    parameter int          LEAK      = 1,
    parameter int          REFRAC    = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [NIN*W-1:0]         in_bus,
    output logic                     spike,
    output logic [$clog2(NIN)-1:0]   spike_port,
    output logic [ACC_W-1:0]         acc,
    output logic                     refractory,
    output logic [7:0]               spike_count
);

    localparam int PW  = $clog2(W + 1);
    localparam int EW  = $clog2(NIN * W + 1);
    localparam int NW  = ACC_W + $clog2(NIN * W) + 1;
    localparam int SPW = $clog2(NIN);
    localparam int RW  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    localparam logic signed [NW-1:0] ACC_MAX  = NW'((1 << ACC_W) - 1);
    localparam logic signed [NW-1:0] LEAK_V   = NW'(LEAK);
    localparam logic [ACC_W-1:0]     THR      = ACC_W'(THRESH);
    localparam logic [RW-1:0]        REFRAC_V = RW'(REFRAC);

    logic [15:0]             lfsr;
    logic [RW-1:0]           rcnt;
    logic [PW-1:0]           pcnt [NIN];
    logic [PW-1:0]           best;
    logic [EW-1:0]           exc;
    logic [SPW-1:0]          win;
    logic signed [NW-1:0]    sum;
    logic [ACC_W-1:0]        nxt;
    logic                    fire;

    // Strict '>' keeps the lowest tied port; '>=' (lfsr[0]=1) lets later ties win.
    always_comb begin
        exc  = '0;
        win  = '0;
        best = '0;
        for (int i = 0; i < NIN; i++) begin
            pcnt[i] = '0;
            for (int b = 0; b < W; b++) begin
                pcnt[i] = pcnt[i] + PW'(in_bus[i*W + b]);
            end
            exc = exc + EW'(pcnt[i]);
            if ((pcnt[i] > best) || (lfsr[0] && (pcnt[i] == best))) begin
                best = pcnt[i];
                win  = SPW'(i);
            end
        end
    end

    always_comb begin
        sum = $signed({{(NW-ACC_W){1'b0}}, acc})
            + $signed({{(NW-EW){1'b0}}, exc})
            - LEAK_V;
        if (sum < 0) begin
            nxt = '0;
        end else if (sum > ACC_MAX) begin
            nxt = '1;
        end else begin
            nxt = sum[ACC_W-1:0];
        end
        fire = (nxt >= THR);
    end

    assign refractory = (rcnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            spike       <= 1'b0;
            spike_port  <= '0;
            rcnt        <= '0;
            spike_count <= '0;
        end else begin
            spike <= 1'b0;
            if (ena) begin
                if (rcnt != '0) begin
                    rcnt <= rcnt - 1'b1;
                    acc  <= '0;
                end else if (fire) begin
                    acc         <= '0;
                    spike       <= 1'b1;
                    spike_port  <= win;
                    rcnt        <= REFRAC_V;
                    spike_count <= spike_count + 8'd1;
                end else begin
                    acc <= nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_lif_cell_array.sv
// tb/tb_lif_cell_array.sv - self-checking bench for lif_cell_array: vector table,
// corner sequences and randomized run against a behavioural model.
module tb_lif_cell_array;

    localparam int          NIN    = 4;
    localparam int          W      = 4;
    localparam int          ACC_W  = 8;
    localparam int          THRESH = 16;
    localparam int          LEAK   = 1;
    localparam int          REFRAC = 3;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             ena = 1'b0;
    logic [NIN*W-1:0] in_bus = '0;
    logic             spike;
    logic [1:0]       spike_port;
    logic [ACC_W-1:0] acc;
    logic             refractory;
    logic [7:0]       spike_count;

    lif_cell_array #(
        .NIN(NIN), .W(W), .ACC_W(ACC_W), .THRESH(THRESH),
        .LEAK(LEAK), .REFRAC(REFRAC), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_bus(in_bus),
        .spike(spike), .spike_port(spike_port), .acc(acc),
        .refractory(refractory), .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_acc, m_rc, m_sc, m_sp;
    bit          m_spike;
    logic [15:0] m_lfsr;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_rc = 0; m_sc = 0; m_sp = 0; m_spike = 0;
        m_lfsr = SEED;
    endtask

    // One clock edge of the reference neuron, evaluated from current inputs.
    task automatic model_edge();
        int cnt [NIN];
        int e, n, best;
        bit pick_high;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e = 0;
        best = 0;
        for (int i = 0; i < NIN; i++) begin
            cnt[i] = $countones(in_bus[i*W +: W]);
            e += cnt[i];
            if (cnt[i] > best) best = cnt[i];
        end
        pick_high = m_lfsr[0];
        m_spike = 0;
        if (ena) begin
            if (m_rc > 0) begin
                m_rc--;
                m_acc = 0;
            end else begin
                n = m_acc + e - LEAK;
                if (n < 0) n = 0;
                if (n > (1 << ACC_W) - 1) n = (1 << ACC_W) - 1;
                if (n >= THRESH) begin
                    m_acc = 0;
                    m_spike = 1;
                    m_rc = REFRAC;
                    m_sc = (m_sc + 1) % 256;
                    m_sp = -1;
                    for (int i = 0; i < NIN; i++) begin
                        if (cnt[i] == best && (pick_high || m_sp < 0)) m_sp = i;
                    end
                end else begin
                    m_acc = n;
                end
            end
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    task automatic tick(input bit cmp);
        model_edge();
        @(posedge clk);
        #1;
        if (cmp) begin
            chk("rnd_acc",   int'(acc),         m_acc);
            chk("rnd_spike", int'(spike),       int'(m_spike));
            chk("rnd_port",  int'(spike_port),  m_sp);
            chk("rnd_refr",  int'(refractory),  int'(m_rc != 0));
            chk("rnd_cnt",   int'(spike_count), m_sc);
        end
    endtask

    // Called one time unit after an edge, so assert/release never meet a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit               en;
        logic [NIN*W-1:0] bus;
        int               e_acc;
        bit               e_spike;
        bit               e_refr;
        int               e_port;
        int               e_cnt;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int fires;
        int seen;
        bit ok;

        // Integrate/fire from reset, then leak-floor after a second reset.
        tbl[0]  = '{1'b1, 16'h000F,  3, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{1'b1, 16'h000F,  6, 1'b0, 1'b0, 0, 0};
        tbl[2]  = '{1'b1, 16'h000F,  9, 1'b0, 1'b0, 0, 0};
        tbl[3]  = '{1'b1, 16'h000F, 12, 1'b0, 1'b0, 0, 0};
        tbl[4]  = '{1'b1, 16'h000F, 15, 1'b0, 1'b0, 0, 0};
        tbl[5]  = '{1'b1, 16'h000F,  0, 1'b1, 1'b1, 0, 1};
        tbl[6]  = '{1'b1, 16'h000F,  0, 1'b0, 1'b1, 0, 1};
        tbl[7]  = '{1'b1, 16'h000F,  0, 1'b0, 1'b1, 0, 1};
        tbl[8]  = '{1'b1, 16'h000F,  0, 1'b0, 1'b0, 0, 1};
        tbl[9]  = '{1'b1, 16'h000F,  3, 1'b0, 1'b0, 0, 1};
        tbl[10] = '{1'b1, 16'h000F,  3, 1'b0, 1'b0, 0, 0};
        tbl[11] = '{1'b1, 16'h0000,  2, 1'b0, 1'b0, 0, 0};
        tbl[12] = '{1'b1, 16'h0000,  1, 1'b0, 1'b0, 0, 0};
        tbl[13] = '{1'b1, 16'h0000,  0, 1'b0, 1'b0, 0, 0};
        tbl[14] = '{1'b1, 16'h0000,  0, 1'b0, 1'b0, 0, 0};
        tbl[15] = '{1'b1, 16'h0000,  0, 1'b0, 1'b0, 0, 0};

        // Asynchronous reset before any clock edge.
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_acc",   int'(acc),         0);
        chk("rst_spike", int'(spike),       0);
        chk("rst_port",  int'(spike_port),  0);
        chk("rst_refr",  int'(refractory),  0);
        chk("rst_cnt",   int'(spike_count), 0);
        tick(0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            if (i == 10) do_reset();
            ena    = tbl[i].en;
            in_bus = tbl[i].bus;
            tick(0);
            chk($sformatf("tbl%0d_acc", i),   int'(acc),         tbl[i].e_acc);
            chk($sformatf("tbl%0d_spike", i), int'(spike),       int'(tbl[i].e_spike));
            chk($sformatf("tbl%0d_refr", i),  int'(refractory),  int'(tbl[i].e_refr));
            chk($sformatf("tbl%0d_port", i),  int'(spike_port),  tbl[i].e_port);
            chk($sformatf("tbl%0d_cnt", i),   int'(spike_count), tbl[i].e_cnt);
        end

        // Enable hold: pause 5 cycles at acc=9, firing moves from edge 6 to edge 11.
        do_reset();
        ena = 1'b1;
        in_bus = 16'h000F;
        for (int i = 0; i < 3; i++) tick(0);
        chk("hold_pre_acc", int'(acc), 9);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(0);
            chk("hold_acc",   int'(acc),   9);
            chk("hold_spike", int'(spike), 0);
        end
        ena = 1'b1;
        tick(0);
        chk("hold_resume1", int'(acc), 12);
        tick(0);
        chk("hold_resume2", int'(acc), 15);
        chk("hold_nospike", int'(spike), 0);
        tick(0);
        chk("hold_fire", int'(spike), 1);
        tick(0);
        chk("hold_fire_once", int'(spike), 0);

        // Tie between ports 1 and 3 at several LFSR phases.
        for (int k = 0; k < 6; k++) begin
            do_reset();
            ena = 1'b1;
            in_bus = '0;
            for (int j = 0; j < k; j++) tick(0);
            in_bus = 16'hF0F0;
            tick(0);
            tick(0);
            chk("tie_nofire_yet", int'(spike), 0);
            tick(0);
            chk("tie_spike", int'(spike), 1);
            chk("tie_port_model", int'(spike_port), m_sp);
            ok = (spike_port == 2'd1) || (spike_port == 2'd3);
            chk("tie_port_legal", int'(ok), 1);
        end

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            ena = ($urandom_range(0, 7) != 0);
            if ((i / 100) % 2 == 0)
                in_bus = 16'($urandom) & 16'($urandom) & 16'($urandom);
            else
                in_bus = 16'($urandom) & 16'($urandom);
            tick(1);
        end

        // 256 firings wrap the counter; reset in the firing cycle then aborts it.
        do_reset();
        ena = 1'b1;
        in_bus = 16'hFFFF;
        fires = 0;
        seen = 0;
        while (fires < 256 && seen < 3000) begin
            tick(1);
            seen++;
            if (spike) fires++;
        end
        chk("wrap_fires", fires, 256);
        chk("wrap_cnt",   int'(spike_count), 0);
        chk("abort_pre_refr", int'(refractory), 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort_refr",  int'(refractory),  0);
        chk("abort_acc",   int'(acc),         0);
        chk("abort_spike", int'(spike),       0);
        chk("abort_cnt",   int'(spike_count), 0);
        rst_n = 1'b1;
        in_bus = '0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("abort_after_spike", int'(spike), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
